// File: rtl/cpu_stack_unit.sv
// cpu_stack_unit: data/return stack engine with register tops, RAM spill, exact depth and atomic fault suppression
module cpu_stack_unit #(
    parameter int DW     = 32,
    parameter int DDEPTH = 256,
    parameter int RDEPTH = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [2:0]                   dop,
    input  logic [DW-1:0]                din,
    input  logic [1:0]                   rop,
    input  logic [DW-1:0]                rdin,
    input  logic                         err_clr,
    output logic [DW-1:0]                tos,
    output logic [DW-1:0]                nos,
    output logic [DW-1:0]                rtos,
    output logic [$clog2(DDEPTH+3)-1:0]  ddepth,
    output logic [$clog2(RDEPTH+2)-1:0]  rdepth,
    output logic                         d_ovf,
    output logic                         d_unf,
    output logic                         r_ovf,
    output logic                         r_unf,
    output logic                         trap
);
    localparam int DDW = $clog2(DDEPTH+3);
    localparam int RDW = $clog2(RDEPTH+2);
    localparam int DAW = $clog2(DDEPTH);
    localparam int RAW = $clog2(RDEPTH);
    localparam logic [2:0] D_PUSH = 3'd1, D_DROP = 3'd2, D_REPL = 3'd3, D_POPREPL = 3'd4;
    localparam logic [2:0] D_SWAP = 3'd5, D_OVER = 3'd6, D_ROT = 3'd7;
    localparam logic [1:0] R_PUSH = 2'd1, R_POP = 2'd2, R_REPL = 2'd3;
    logic [DW-1:0]  dram [DDEPTH];
    logic [DW-1:0]  rram [RDEPTH];
    logic [DW-1:0]  dram_q, dbyp_d, rram_q, rbyp_d, third, rsec;
    logic           dbyp, rbyp;
    logic [DW-1:0]  n_tos, n_nos, n_rtos, d_wd;
    logic [DDW-1:0] n_d;
    logic [RDW-1:0] n_rd;
    logic [DAW-1:0] d_wa, d_ra;
    logic [RAW-1:0] r_wa, r_ra;
    logic           d_we, r_we;
    logic [1:0]     d_need;
    logic           d_e_ovf, d_e_unf, r_e_ovf, r_e_unf, err;
    assign d_need  = (dop == D_ROT) ? 2'd3 :
                     (dop == D_POPREPL || dop == D_SWAP || dop == D_OVER) ? 2'd2 :
                     (dop == D_DROP || dop == D_REPL) ? 2'd1 : 2'd0;
    assign d_e_unf = ddepth < DDW'(d_need);
    assign d_e_ovf = (dop == D_PUSH || dop == D_OVER) && ddepth == DDW'(DDEPTH+2);
    assign r_e_unf = (rop == R_POP || rop == R_REPL) && rdepth == '0;
    assign r_e_ovf = rop == R_PUSH && rdepth == RDW'(RDEPTH+1);
    assign err     = d_e_ovf | d_e_unf | r_e_ovf | r_e_unf;
    assign third   = (ddepth >= DDW'(3)) ? (dbyp ? dbyp_d : dram_q) : '0;
    assign rsec    = (rdepth >= RDW'(2)) ? (rbyp ? rbyp_d : rram_q) : '0;
    assign d_wd    = nos;
    assign r_wa    = RAW'(rdepth) - RAW'(1);
    assign d_ra    = DAW'(n_d) - DAW'(3);
    assign r_ra    = RAW'(n_rd) - RAW'(2);
    // Data stack next state; a fault anywhere in the cycle freezes everything
    always_comb begin
        n_tos = tos;
        n_nos = nos;
        n_d   = ddepth;
        d_we  = 1'b0;
        d_wa  = DAW'(ddepth) - DAW'(2);
        if (!err) begin
            case (dop)
                D_PUSH:    begin n_tos = din; n_nos = tos; n_d = ddepth + DDW'(1); d_we = ddepth >= DDW'(2); end
                D_DROP:    begin n_tos = nos; n_nos = third; n_d = ddepth - DDW'(1); end
                D_REPL:    n_tos = din;
                D_POPREPL: begin n_tos = din; n_nos = third; n_d = ddepth - DDW'(1); end
                D_SWAP:    begin n_tos = nos; n_nos = tos; end
                D_OVER:    begin n_tos = nos; n_nos = tos; n_d = ddepth + DDW'(1); d_we = 1'b1; end
                D_ROT:     begin n_tos = third; n_nos = tos; d_we = 1'b1; d_wa = DAW'(ddepth) - DAW'(3); end
                default:   ;
            endcase
        end
    end
    // Return stack next state, suppressed together with the data op
    always_comb begin
        n_rtos = rtos;
        n_rd   = rdepth;
        r_we   = 1'b0;
        if (!err) begin
            case (rop)
                R_PUSH:  begin n_rtos = rdin; n_rd = rdepth + RDW'(1); r_we = rdepth >= RDW'(1); end
                R_POP:   begin n_rtos = rsec; n_rd = rdepth - RDW'(1); end
                R_REPL:  n_rtos = rdin;
                default: ;
            endcase
        end
    end
    // Spill RAMs: read addressed by next-state depth so the output is the deeper entry; bypass covers same-cycle spill
    always_ff @(posedge clk) begin
        if (d_we) dram[d_wa] <= d_wd;
        if (r_we) rram[r_wa] <= rtos;
        dram_q <= dram[d_ra];
        rram_q <= rram[r_ra];
        dbyp   <= d_we && d_wa == d_ra;
        rbyp   <= r_we && r_wa == r_ra;
        dbyp_d <= d_wd;
        rbyp_d <= rtos;
    end
    // Architectural registers, sticky flags and the trap pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            tos    <= '0;
            nos    <= '0;
            rtos   <= '0;
            ddepth <= '0;
            rdepth <= '0;
            d_ovf  <= 1'b0;
            d_unf  <= 1'b0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
            trap   <= 1'b0;
        end else begin
            tos    <= n_tos;
            nos    <= n_nos;
            rtos   <= n_rtos;
            ddepth <= n_d;
            rdepth <= n_rd;
            d_ovf  <= (d_ovf & ~err_clr) | d_e_ovf;
            d_unf  <= (d_unf & ~err_clr) | d_e_unf;
            r_ovf  <= (r_ovf & ~err_clr) | r_e_ovf;
            r_unf  <= (r_unf & ~err_clr) | r_e_unf;
            trap   <= err;
        end
    end
endmodule

// File: tb/tb_cpu_stack_unit.sv
// tb_cpu_stack_unit: queue-model scoreboard for cpu_stack_unit with directed edge cases and random ops
module tb_cpu_stack_unit;
    localparam int DCAP = 6;
    localparam int RCAP = 5;
    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, DROP = 3'd2, REPL = 3'd3, POPREPL = 3'd4;
    localparam logic [2:0] SWAP = 3'd5, OVER = 3'd6, ROT = 3'd7;
    localparam logic [1:0] RNOP = 2'd0, RPUSH = 2'd1, RPOP = 2'd2, RREPL = 2'd3;
    typedef struct packed {
        logic [31:0] tos, nos, rtos;
        logic [2:0]  dd, rd;
        logic        dov, dun, rov, run, trap;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  dop = '0;
    logic [31:0] din = '0;
    logic [1:0]  rop = '0;
    logic [31:0] rdin = '0;
    logic        err_clr = 1'b0;
    logic [31:0] tos, nos, rtos;
    logic [2:0]  ddepth, rdepth;
    logic        d_ovf, d_unf, r_ovf, r_unf, trap;
    int          checks = 0;
    int          failures = 0;
    exp_t        exp_q[$];
    exp_t        pend;
    logic        pend_v = 1'b0;
    logic [31:0] ds[$];
    logic [31:0] rs[$];
    logic        m_dov = 1'b0, m_dun = 1'b0, m_rov = 1'b0, m_run = 1'b0, m_trap = 1'b0;
    cpu_stack_unit #(.DW(32), .DDEPTH(4), .RDEPTH(4)) dut (
        .clk(clk), .rst(rst), .dop(dop), .din(din), .rop(rop), .rdin(rdin), .err_clr(err_clr),
        .tos(tos), .nos(nos), .rtos(rtos), .ddepth(ddepth), .rdepth(rdepth),
        .d_ovf(d_ovf), .d_unf(d_unf), .r_ovf(r_ovf), .r_unf(r_unf), .trap(trap)
    );
    always #5 clk = ~clk;
    function automatic logic [31:0] mtos();
        return ds.size() > 0 ? ds[ds.size()-1] : 32'd0;
    endfunction
    function automatic logic [31:0] mrtos();
        return rs.size() > 0 ? rs[rs.size()-1] : 32'd0;
    endfunction
    function automatic exp_t snap();
        exp_t e;
        e.tos  = mtos();
        e.nos  = ds.size() > 1 ? ds[ds.size()-2] : 32'd0;
        e.rtos = mrtos();
        e.dd   = 3'(ds.size());
        e.rd   = 3'(rs.size());
        e.dov  = m_dov;
        e.dun  = m_dun;
        e.rov  = m_rov;
        e.run  = m_run;
        e.trap = m_trap;
        return e;
    endfunction
    // Stack-effect reference model over plain queues (back of queue is the top)
    task automatic model(input logic r, input logic [2:0] o, input logic [31:0] d,
                         input logic [1:0] ro, input logic [31:0] rd, input logic c);
        int n, need;
        logic eo, eu, reo, reu;
        logic [31:0] t;
        if (r) begin
            ds.delete();
            rs.delete();
            {m_dov, m_dun, m_rov, m_run, m_trap} = '0;
            return;
        end
        n    = ds.size();
        need = (o == ROT) ? 3 : (o == POPREPL || o == SWAP || o == OVER) ? 2 : (o == DROP || o == REPL) ? 1 : 0;
        eu   = n < need;
        eo   = (o == PUSH || o == OVER) && n == DCAP;
        reu  = (ro == RPOP || ro == RREPL) && rs.size() == 0;
        reo  = ro == RPUSH && rs.size() == RCAP;
        if (!(eu | eo | reu | reo)) begin
            case (o)
                PUSH:    ds.push_back(d);
                DROP:    ds.delete(n-1);
                REPL:    ds[n-1] = d;
                POPREPL: begin ds.delete(n-1); ds[n-2] = d; end
                SWAP:    begin t = ds[n-1]; ds[n-1] = ds[n-2]; ds[n-2] = t; end
                OVER:    begin t = ds[n-2]; ds.push_back(t); end
                ROT:     begin t = ds[n-3]; ds[n-3] = ds[n-2]; ds[n-2] = ds[n-1]; ds[n-1] = t; end
                default: ;
            endcase
            case (ro)
                RPUSH:   rs.push_back(rd);
                RPOP:    rs.delete(rs.size()-1);
                RREPL:   rs[rs.size()-1] = rd;
                default: ;
            endcase
        end
        m_dov  = (m_dov & ~c) | eo;
        m_dun  = (m_dun & ~c) | eu;
        m_rov  = (m_rov & ~c) | reo;
        m_run  = (m_run & ~c) | reu;
        m_trap = eu | eo | reu | reo;
    endtask
    // Issue one op just after an edge; the previous op's expectation is released once its edge has passed
    task automatic step(input logic r, input logic [2:0] o, input logic [31:0] d,
                        input logic [1:0] ro, input logic [31:0] rd, input logic c);
        @(posedge clk);
        if (pend_v) exp_q.push_back(pend);
        #1;
        rst = r; dop = o; din = d; rop = ro; rdin = rd; err_clr = c;
        model(r, o, d, ro, rd, c);
        pend   = snap();
        pend_v = 1'b1;
    endtask
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask
    // Monitor: every cycle the DUT presents state, compare against the oldest released expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("tos", tos, e.tos);
                chk("nos", nos, e.nos);
                chk("rtos", rtos, e.rtos);
                chk("ddepth", 32'(ddepth), 32'(e.dd));
                chk("rdepth", 32'(rdepth), 32'(e.rd));
                chk("flags", {28'd0, d_ovf, d_unf, r_ovf, r_unf}, {28'd0, e.dov, e.dun, e.rov, e.run});
                chk("trap", 32'(trap), 32'(e.trap));
            end
        end
    end
    initial begin
        int k;
        step(1, NOP, 0, RNOP, 0, 0);
        step(0, PUSH, 1, RNOP, 0, 0);
        step(0, PUSH, 2, RNOP, 0, 0);
        step(0, PUSH, 3, RNOP, 0, 0);
        step(0, ROT, 0, RNOP, 0, 0);
        for (int i = 0; i < 3; i++) step(0, DROP, 0, RNOP, 0, 0);
        for (int i = 1; i <= 7; i++) step(0, PUSH, 32'(i), RNOP, 0, 0);
        for (int i = 0; i < 6; i++) step(0, DROP, 0, RNOP, 0, 0);
        step(0, NOP, 0, RNOP, 0, 1);
        for (int i = 1; i <= 3; i++) step(0, PUSH, 32'(i + 16), RNOP, 0, 0);
        step(0, PUSH, 32'hA, RNOP, 0, 0);
        step(0, DROP, 0, RNOP, 0, 0);
        step(0, PUSH, 32'hB, RNOP, 0, 0);
        step(0, DROP, 0, RNOP, 0, 0);
        step(0, OVER, 0, RNOP, 0, 0);
        step(0, SWAP, 0, RNOP, 0, 0);
        step(0, POPREPL, 32'h55, RNOP, 0, 0);
        for (int i = 1; i <= RCAP; i++) step(0, NOP, 0, RPUSH, 32'(i + 100), 0);
        step(0, DROP, 0, RPUSH, mtos(), 0);
        step(0, NOP, 0, RPOP, 0, 1);
        step(0, DROP, 0, RPUSH, mtos(), 0);
        step(0, PUSH, mrtos(), RPOP, 0, 0);
        step(0, NOP, 0, RREPL, 32'h77, 0);
        while (ds.size() > 0) step(0, DROP, 0, RNOP, 0, 0);
        while (rs.size() > 0) step(0, NOP, 0, RPOP, 0, 0);
        step(0, DROP, 0, RPOP, 0, 1);
        step(0, NOP, 0, RNOP, 0, 1);
        for (int i = 1; i <= 5; i++) step(0, PUSH, 32'(i), RPUSH, 32'(i), 0);
        step(1, PUSH, 32'h9, RNOP, 0, 0);
        step(0, PUSH, 32'h7, RNOP, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            k = int'($urandom_range(0, 5));
            step(($urandom_range(0, 199) == 0), 3'($urandom_range(0, 7)), $urandom,
                 (k > 3) ? RNOP : 2'(k), $urandom, ($urandom_range(0, 7) == 0));
        end
        step(0, NOP, 0, RNOP, 0, 0);
        @(posedge clk);
        exp_q.push_back(pend);
        k = 0;
        while (exp_q.size() > 0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
